// File: rtl/rgb_effect_pkg.sv
// Shared types and helpers for the RGB effect engine: mode/direction encodings,
// level/duty ceilings and the exact-integer gamma curve.
package rgb_effect_pkg;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_STATIC  = 2'd1,
        MODE_BREATHE = 2'd2,
        MODE_BLINK   = 2'd3
    } mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    function automatic int unsigned lmax(input int unsigned bw);
        return (32'd1 << bw) - 32'd1;
    endfunction

    function automatic int unsigned dmax(input int unsigned dw);
        return (32'd1 << dw) - 32'd1;
    endfunction

    // floor(level^2 * DMAX / LMAX^2), evaluated in 64 bits so no term truncates
    function automatic logic [63:0] gamma_map(input logic [63:0] lvl,
                                              input int unsigned bw,
                                              input int unsigned dw);
        logic [63:0] l;
        l = 64'(lmax(bw));
        return (lvl * lvl * 64'(dmax(dw))) / (l * l);
    endfunction

endpackage

// File: rtl/rgb_effect_engine_if.sv
// Configuration handshake bundle for rgb_effect_engine (valid/ready plus payload).
interface rgb_effect_engine_if #(
    parameter int unsigned CH       = 3,
    parameter int unsigned BRIGHT_W = 4,
    parameter int unsigned DUTY_W   = 8,
    parameter int unsigned RATE_W   = 8
);
    logic                   cfg_valid;
    logic                   cfg_ready;
    logic [1:0]             cfg_mode;
    logic [BRIGHT_W-1:0]    cfg_level;
    logic [RATE_W-1:0]      cfg_rate;
    logic [CH-1:0]          cfg_mask;
    logic [CH*DUTY_W-1:0]   cfg_gain;

    modport master (
        output cfg_valid, cfg_mode, cfg_level, cfg_rate, cfg_mask, cfg_gain,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_mode, cfg_level, cfg_rate, cfg_mask, cfg_gain,
        output cfg_ready
    );
endinterface

// File: rtl/rgb_effect_seq.sv
// Timing core: PWM prescaler and period counter, animation step counter and the
// level/direction sequencer for OFF/STATIC/BREATHE/BLINK.
module rgb_effect_seq
    import rgb_effect_pkg::*;
#(
    parameter int unsigned BRIGHT_W = 4,
    parameter int unsigned DUTY_W   = 8,
    parameter int unsigned PWM_DIV  = 1,
    parameter int unsigned RATE_W   = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                apply,
    input  mode_e               new_mode,
    input  logic [BRIGHT_W-1:0] new_level,
    input  logic [RATE_W-1:0]   new_rate,
    output logic [DUTY_W-1:0]   pwm_cnt,
    output logic                wrap,
    output logic [BRIGHT_W-1:0] level,
    output logic                trough
);
    localparam int unsigned DIV_W = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
    localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(PWM_DIV - 1);
    localparam logic [BRIGHT_W-1:0] LMAX_V   = '1;
    localparam logic [BRIGHT_W-1:0] LVL_ONE  = BRIGHT_W'(1);

    logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
    logic [DUTY_W-1:0]   pwm_cnt_q, pwm_cnt_d;
    logic [RATE_W-1:0]   anim_cnt_q, anim_cnt_d;
    logic [RATE_W-1:0]   rate_q, rate_d;
    logic [RATE_W-1:0]   r_last;
    logic [BRIGHT_W-1:0] level_q, level_d;
    mode_e               mode_q, mode_d;
    dir_e                dir_q, dir_d;
    logic                tick;
    logic                step;

    always_comb begin
        tick      = (div_cnt_q == DIV_LAST);
        div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
        pwm_cnt_d = tick ? pwm_cnt_q + 1'b1 : pwm_cnt_q;
        wrap      = tick && (pwm_cnt_q == '1);
        r_last    = (rate_q == '0) ? '0 : rate_q - 1'b1;
        // >= keeps stepping promptly if a rate decrease left the counter past its new end
        step      = tick && (anim_cnt_q >= r_last);
    end

    always_comb begin
        dir_d      = dir_q;
        level_d    = level_q;
        mode_d     = mode_q;
        rate_d     = rate_q;
        anim_cnt_d = anim_cnt_q;
        trough     = 1'b0;

        if (tick) begin
            anim_cnt_d = step ? '0 : anim_cnt_q + 1'b1;
        end

        if (step) begin
            case (mode_q)
                MODE_BREATHE: begin
                    if (dir_q == DIR_UP) begin
                        if (level_q == LMAX_V) begin
                            dir_d   = DIR_DOWN;
                            level_d = LMAX_V - 1'b1;
                        end else begin
                            level_d = level_q + 1'b1;
                        end
                    end else begin
                        if (level_q == '0) begin
                            dir_d   = DIR_UP;
                            level_d = LVL_ONE;
                        end else begin
                            level_d = level_q - 1'b1;
                            trough  = (level_q == LVL_ONE);
                        end
                    end
                end
                MODE_BLINK: level_d = (level_q == '0) ? LMAX_V : '0;
                default: ;
            endcase
        end

        if (apply) begin
            mode_d = new_mode;
            rate_d = new_rate;
            if (new_mode != mode_q) begin
                level_d    = '0;
                dir_d      = DIR_UP;
                anim_cnt_d = '0;
                trough     = 1'b0;
            end
            if (new_mode == MODE_STATIC) begin
                level_d = new_level;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q  <= '0;
            pwm_cnt_q  <= '0;
            anim_cnt_q <= '0;
            rate_q     <= RATE_W'(1);
            level_q    <= '0;
            mode_q     <= MODE_OFF;
            dir_q      <= DIR_UP;
        end else begin
            div_cnt_q  <= div_cnt_d;
            pwm_cnt_q  <= pwm_cnt_d;
            anim_cnt_q <= anim_cnt_d;
            rate_q     <= rate_d;
            level_q    <= level_d;
            mode_q     <= mode_d;
            dir_q      <= dir_d;
        end
    end

    assign pwm_cnt = pwm_cnt_q;
    assign level   = level_q;

endmodule

// File: rtl/rgb_effect_engine.sv
// N-channel LED effect engine: config handshake with period-aligned apply,
// gamma + per-channel gain duty, registered PWM. COLOR_CYCLE_EN rotates the mask at BREATHE troughs.
module rgb_effect_engine
    import rgb_effect_pkg::*;
#(
    parameter int unsigned CH       = 3,
    parameter int unsigned BRIGHT_W = 4,
    parameter int unsigned DUTY_W   = 8,
    parameter int unsigned PWM_DIV  = 1,
    parameter int unsigned RATE_W   = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    rgb_effect_engine_if.slave  cfg,
    output logic [CH-1:0]       pwm_out,
    output logic [BRIGHT_W-1:0] level,
    output logic                period_start
);
    localparam logic [DUTY_W-1:0] DMAX_V = '1;

    logic                      pending_q, pending_d;
    mode_e                     sh_mode_q, sh_mode_d;
    logic [BRIGHT_W-1:0]       sh_level_q, sh_level_d;
    logic [RATE_W-1:0]         sh_rate_q, sh_rate_d;
    logic [CH-1:0]             sh_mask_q, sh_mask_d;
    logic [CH*DUTY_W-1:0]      sh_gain_q, sh_gain_d;
    logic [CH-1:0]             mask_q, mask_d;
    logic [CH*DUTY_W-1:0]      gain_q, gain_d;
    logic [CH-1:0]             pwm_out_q, pwm_out_d;
    logic                      period_start_q, period_start_d;
    logic                      accept, apply, wrap, trough;
    logic [DUTY_W-1:0]         pwm_cnt, gamma_val;
    logic [BRIGHT_W-1:0]       seq_level;
    logic [CH-1:0][DUTY_W-1:0] duty;

    rgb_effect_seq #(
        .BRIGHT_W (BRIGHT_W),
        .DUTY_W   (DUTY_W),
        .PWM_DIV  (PWM_DIV),
        .RATE_W   (RATE_W)
    ) u_seq (
        .clk       (clk),
        .rst_n     (rst_n),
        .apply     (apply),
        .new_mode  (sh_mode_q),
        .new_level (sh_level_q),
        .new_rate  (sh_rate_q),
        .pwm_cnt   (pwm_cnt),
        .wrap      (wrap),
        .level     (seq_level),
        .trough    (trough)
    );

    // ready is simply "nothing pending", so accept and apply can never coincide
    always_comb begin
        accept         = cfg.cfg_valid && !pending_q;
        apply          = wrap && pending_q;
        pending_d      = pending_q;
        sh_mode_d      = sh_mode_q;
        sh_level_d     = sh_level_q;
        sh_rate_d      = sh_rate_q;
        sh_mask_d      = sh_mask_q;
        sh_gain_d      = sh_gain_q;
        mask_d         = mask_q;
        gain_d         = gain_q;
        period_start_d = wrap;

        if (accept) begin
            pending_d  = 1'b1;
            sh_mode_d  = mode_e'(cfg.cfg_mode);
            sh_level_d = cfg.cfg_level;
            sh_rate_d  = cfg.cfg_rate;
            sh_mask_d  = cfg.cfg_mask;
            sh_gain_d  = cfg.cfg_gain;
        end

        if (apply) begin
            pending_d = 1'b0;
            mask_d    = sh_mask_q;
            gain_d    = sh_gain_q;
        end
`ifdef COLOR_CYCLE_EN
        else if (trough) begin
            mask_d = (mask_q << 1) | (mask_q >> (CH - 1));
        end
`endif
    end

    assign gamma_val = DUTY_W'(gamma_map(64'(seq_level), BRIGHT_W, DUTY_W));

    for (genvar i = 0; i < CH; i++) begin : g_duty
        logic [DUTY_W-1:0]   gain_i;
        logic [2*DUTY_W-1:0] prod;
        assign gain_i  = gain_q[i*DUTY_W +: DUTY_W];
        assign prod    = (2*DUTY_W)'(gamma_val) * (2*DUTY_W)'(gain_i);
        assign duty[i] = !mask_q[i]         ? '0 :
                         (gain_i == DMAX_V) ? gamma_val :
                                              prod[2*DUTY_W-1:DUTY_W];
    end

    always_comb begin
        pwm_out_d = '0;
        for (int unsigned i = 0; i < CH; i++) begin
            pwm_out_d[i] = (pwm_cnt < duty[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q      <= 1'b0;
            sh_mode_q      <= MODE_OFF;
            sh_level_q     <= '0;
            sh_rate_q      <= '0;
            sh_mask_q      <= '0;
            sh_gain_q      <= '0;
            mask_q         <= '0;
            gain_q         <= '1;
            pwm_out_q      <= '0;
            period_start_q <= 1'b0;
        end else begin
            pending_q      <= pending_d;
            sh_mode_q      <= sh_mode_d;
            sh_level_q     <= sh_level_d;
            sh_rate_q      <= sh_rate_d;
            sh_mask_q      <= sh_mask_d;
            sh_gain_q      <= sh_gain_d;
            mask_q         <= mask_d;
            gain_q         <= gain_d;
            pwm_out_q      <= pwm_out_d;
            period_start_q <= period_start_d;
        end
    end

    assign cfg.cfg_ready = !pending_q;
    assign pwm_out       = pwm_out_q;
    assign level         = seq_level;
    assign period_start  = period_start_q;

endmodule

// File: tb/tb_rgb_effect_engine.sv
// Directed self-checking bench for rgb_effect_engine (CH=3, BRIGHT_W=4, DUTY_W=8, PWM_DIV=1).
module tb_rgb_effect_engine;
    localparam int unsigned CH = 3;
    localparam int unsigned BW = 4;
    localparam int unsigned DW = 8;
    localparam int unsigned RW = 8;
`ifdef COLOR_CYCLE_EN
    localparam logic [CH-1:0] WIN1_EXP = 3'b010;
    localparam logic [CH-1:0] WIN2_EXP = 3'b100;
`else
    localparam logic [CH-1:0] WIN1_EXP = 3'b001;
    localparam logic [CH-1:0] WIN2_EXP = 3'b001;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rgb_effect_engine_if #(.CH(CH), .BRIGHT_W(BW), .DUTY_W(DW), .RATE_W(RW)) cfg_if ();

    logic [CH-1:0] pwm_out;
    logic [BW-1:0] level;
    logic          period_start;

    rgb_effect_engine #(
        .CH(CH), .BRIGHT_W(BW), .DUTY_W(DW), .PWM_DIV(1), .RATE_W(RW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg          (cfg_if),
        .pwm_out      (pwm_out),
        .level        (level),
        .period_start (period_start)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic offer(input logic [1:0] m, input logic [BW-1:0] l, input logic [RW-1:0] r,
                         input logic [CH-1:0] mk, input logic [CH*DW-1:0] g);
        cfg_if.cfg_mode  = m;
        cfg_if.cfg_level = l;
        cfg_if.cfg_rate  = r;
        cfg_if.cfg_mask  = mk;
        cfg_if.cfg_gain  = g;
        cfg_if.cfg_valid = 1'b1;
    endtask

    // Called at a negedge with cfg_ready high; returns one negedge later with valid dropped.
    task automatic send(input logic [1:0] m, input logic [BW-1:0] l, input logic [RW-1:0] r,
                        input logic [CH-1:0] mk, input logic [CH*DW-1:0] g);
        offer(m, l, r, mk, g);
        @(negedge clk);
        cfg_if.cfg_valid = 1'b0;
    endtask

    task automatic wait_ps(output logic [BW-1:0] prev_level, output logic prev_ready);
        bit found = 0;
        prev_level = level;
        prev_ready = cfg_if.cfg_ready;
        for (int i = 0; i < 600 && !found; i++) begin
            prev_level = level;
            prev_ready = cfg_if.cfg_ready;
            @(negedge clk);
            if (period_start) found = 1;
        end
        check("period_start_seen", 64'(found), 64'd1);
    endtask

    // Starts at a period_start negedge; counts high samples over the following full period.
    task automatic measure(output int c0, output int c1, output int c2);
        int ps = 0;
        c0 = 0; c1 = 0; c2 = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            c0 += int'(pwm_out[0]);
            c1 += int'(pwm_out[1]);
            c2 += int'(pwm_out[2]);
            ps += int'(period_start);
        end
        check("period_start_pulses", 64'(ps), 64'd1);
    endtask

    logic [BW-1:0] lv [0:179];
    logic [CH-1:0] pw [0:179];

    initial begin
        logic [BW-1:0] pl;
        logic          pr;
        int c0, c1, c2, bad, e, m, toggles;
        logic [CH-1:0] w1, w2;

        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_mode  = '0;
        cfg_if.cfg_level = '0;
        cfg_if.cfg_rate  = '0;
        cfg_if.cfg_mask  = '0;
        cfg_if.cfg_gain  = '0;

        repeat (3) @(negedge clk);
        check("rst_pwm_out", 64'(pwm_out), 64'd0);
        check("rst_level", 64'(level), 64'd0);
        check("rst_ready", 64'(cfg_if.cfg_ready), 64'd1);
        check("rst_period_start", 64'(period_start), 64'd0);
        rst_n = 1'b1;

        bad = 0;
        repeat (300) begin
            @(negedge clk);
            if (pwm_out !== '0 || level !== '0 || cfg_if.cfg_ready !== 1'b1) bad++;
        end
        check("idle_bad_cycles", 64'(bad), 64'd0);

        // STATIC 15, mask 101
        send(2'd1, 4'd15, 8'd1, 3'b101, {3{8'd255}});
        check("ready_low_after_accept", 64'(cfg_if.cfg_ready), 64'd0);
        wait_ps(pl, pr);
        check("apply_level_before", 64'(pl), 64'd0);
        check("apply_ready_before", 64'(pr), 64'd0);
        check("apply_level_static15", 64'(level), 64'd15);
        check("ready_high_at_period_start", 64'(cfg_if.cfg_ready), 64'd1);
        measure(c0, c1, c2);
        check("s15_ch0_high", 64'(c0), 64'd255);
        check("s15_ch1_high", 64'(c1), 64'd0);
        check("s15_ch2_high", 64'(c2), 64'd255);

        // Same-mode apply with a second offer ignored while pending
        send(2'd1, 4'd8, 8'd1, 3'b101, {3{8'd255}});
        check("ready_low_pending", 64'(cfg_if.cfg_ready), 64'd0);
        offer(2'd1, 4'd3, 8'd1, 3'b111, {3{8'd255}});
        repeat (3) @(negedge clk);
        cfg_if.cfg_valid = 1'b0;
        wait_ps(pl, pr);
        check("s8_level_before", 64'(pl), 64'd15);
        check("s8_ready_before", 64'(pr), 64'd0);
        check("s8_level_applied", 64'(level), 64'd8);
        measure(c0, c1, c2);
        check("s8_ch0_high", 64'(c0), 64'd72);
        check("s8_ch1_high", 64'(c1), 64'd0);
        check("s8_ch2_high", 64'(c2), 64'd72);

        send(2'd1, 4'd1, 8'd1, 3'b101, {3{8'd255}});
        wait_ps(pl, pr);
        measure(c0, c1, c2);
        check("s1_ch0_high", 64'(c0), 64'd1);

        // Gain 128 on ch0 at level 15
        send(2'd1, 4'd15, 8'd1, 3'b111, {8'd255, 8'd255, 8'd128});
        wait_ps(pl, pr);
        measure(c0, c1, c2);
        check("gain128_ch0_high", 64'(c0), 64'd127);
        check("gain128_ch1_high", 64'(c1), 64'd255);
        check("gain128_ch2_high", 64'(c2), 64'd255);

        // BREATHE rate 2, mask 001
        send(2'd2, 4'd0, 8'd2, 3'b001, {3{8'd255}});
        wait_ps(pl, pr);
        for (int k = 0; k < 180; k++) begin
            if (k != 0) @(negedge clk);
            lv[k] = level;
            pw[k] = pwm_out;
        end
        bad = 0;
        for (int k = 0; k < 180; k++) begin
            m = (k / 2) % 30;
            e = (m <= 15) ? m : 30 - m;
            if (lv[k] !== BW'(e)) bad++;
        end
        check("breathe_seq_mismatch", 64'(bad), 64'd0);
        check("breathe_start", 64'(lv[0]), 64'd0);
        check("breathe_peak_a", 64'(lv[30]), 64'd15);
        check("breathe_peak_b", 64'(lv[31]), 64'd15);
        check("breathe_after_peak", 64'(lv[32]), 64'd14);
        check("breathe_trough", 64'(lv[60]), 64'd0);
        check("breathe_trough_hold", 64'(lv[61]), 64'd0);
        check("breathe_after_trough", 64'(lv[62]), 64'd1);
        w1 = '0;
        w2 = '0;
        for (int k = 62; k < 120; k++) w1 |= pw[k];
        for (int k = 122; k < 180; k++) w2 |= pw[k];
        check("breathe_mask_win1", 64'(w1), 64'(WIN1_EXP));
        check("breathe_mask_win2", 64'(w2), 64'(WIN2_EXP));

        // BLINK rate 3
        send(2'd3, 4'd0, 8'd3, 3'b111, {8'd255, 8'd255, 8'd128});
        wait_ps(pl, pr);
        for (int k = 0; k < 8; k++) begin
            if (k != 0) @(negedge clk);
            lv[k] = level;
        end
        check("blink_l0", 64'(lv[0]), 64'd0);
        check("blink_l2", 64'(lv[2]), 64'd0);
        check("blink_l3", 64'(lv[3]), 64'd15);
        check("blink_l5", 64'(lv[5]), 64'd15);
        check("blink_l6", 64'(lv[6]), 64'd0);

        // Rate 0 behaves as 1: toggles on every tick
        send(2'd3, 4'd0, 8'd0, 3'b111, {3{8'd255}});
        wait_ps(pl, pr);
        for (int k = 0; k < 11; k++) begin
            if (k != 0) @(negedge clk);
            lv[k] = level;
        end
        toggles = 0;
        for (int k = 1; k < 11; k++) begin
            if (lv[k] !== lv[k-1] && (lv[k] === 4'd0 || lv[k] === 4'd15)) toggles++;
        end
        check("blink_rate0_toggles", 64'(toggles), 64'd10);

        // Reset mid-operation with a config pending
        send(2'd1, 4'd15, 8'd1, 3'b111, {3{8'd255}});
        check("ready_low_before_reset", 64'(cfg_if.cfg_ready), 64'd0);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_pwm_out", 64'(pwm_out), 64'd0);
        check("midrst_level", 64'(level), 64'd0);
        check("midrst_ready", 64'(cfg_if.cfg_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        repeat (600) begin
            @(negedge clk);
            if (pwm_out !== '0 || level !== '0 || cfg_if.cfg_ready !== 1'b1) bad++;
        end
        check("post_reset_pending_dropped", 64'(bad), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL global_timeout got 0 expected 1");
        $fatal(1, "simulation time limit exceeded");
    end
endmodule
